// File: rtl/control_memw_seq.sv
// Purpose: weight-bank sequencer; issues bank read selects and delayed write-back selects per advance.
// Latency: read strobe 1 cycle after an accepted advance; matching write strobe WB_LAT cycles after that read.
// Backpressure: caller paces with advance (one bank per cycle max); abort cancels and drops pending writes.
module control_memw_seq #(
   parameter int NBANK  = 4,
   parameter int SEL_W  = 2,
   parameter int WB_LAT = 1,
   parameter int NPASS  = 2,
   parameter int PASS_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wb_mode,
   input  logic              advance,
   input  logic              abort,
   output logic              rden_MEMW,
   output logic [SEL_W-1:0]  rdslc_MEMW,
   output logic              wren_MEMW,
   output logic [SEL_W-1:0]  wrslc_MEMW,
   output logic              busy,
   output logic              done,
   output logic [PASS_W-1:0] pass_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [SEL_W-1:0]    bank;
   logic                wb_latched;
   logic [WB_LAT-1:0]   dl_vld;
   logic [SEL_W-1:0]    dl_sel [WB_LAT];

   logic                adv_acc;
   logic                bank_last;
   logic                start_acc;
   logic                push_vld;
   logic [PASS_W-1:0]   pass_inc;

   // Abort outranks advance, so a cancelled cycle never produces a read.
   assign adv_acc   = advance && !abort && (state == S_PRIME || state == S_STREAM);
   assign bank_last = (bank == SEL_W'(NBANK - 1));
   assign start_acc = start && (state == S_IDLE);
   assign push_vld  = adv_acc && (state == S_STREAM) && wb_latched;
   assign pass_inc  = pass_cnt + PASS_W'(1);

   // Next-state decode; start beats abort in IDLE, abort beats everything elsewhere.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_PRIME;
         S_PRIME: begin
            if (abort)                      state_nxt = S_IDLE;
            else if (adv_acc && bank_last)  state_nxt = S_STREAM;
         end
         S_STREAM: begin
            if (abort) state_nxt = S_IDLE;
            else if (adv_acc && bank_last && (pass_inc == PASS_W'(NPASS)))
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)        state_nxt = S_IDLE;
            else if (~|dl_vld) state_nxt = S_DONE;
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Bank pointer, pass counter and latched write-back mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank       <= '0;
         pass_cnt   <= '0;
         wb_latched <= 1'b0;
      end else if (start_acc) begin
         bank       <= '0;
         pass_cnt   <= '0;
         wb_latched <= wb_mode;
      end else if (abort) begin
         bank       <= '0;
      end else if (adv_acc) begin
         bank <= bank_last ? '0 : bank + SEL_W'(1);
         if (state == S_STREAM && bank_last) pass_cnt <= pass_inc;
      end
   end

   // Write-back delay line; the output register forms the final stage, so depth WB_LAT gives WB_LAT cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_vld <= '0;
         for (int i = 0; i < WB_LAT; i++) dl_sel[i] <= '0;
      end else if (abort) begin
         dl_vld <= '0;
      end else begin
         dl_vld[0] <= push_vld;
         dl_sel[0] <= bank;
         for (int i = 1; i < WB_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_sel[i] <= dl_sel[i-1];
         end
      end
   end

   // Registered outputs; selects hold their last value while the strobes are low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rden_MEMW  <= 1'b0;
         rdslc_MEMW <= '0;
         wren_MEMW  <= 1'b0;
         wrslc_MEMW <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         rden_MEMW <= adv_acc;
         if (adv_acc) rdslc_MEMW <= bank;
         wren_MEMW <= dl_vld[WB_LAT-1] && !abort;
         if (dl_vld[WB_LAT-1] && !abort) wrslc_MEMW <= dl_sel[WB_LAT-1];
         busy <= (state_nxt == S_PRIME) || (state_nxt == S_STREAM) || (state_nxt == S_DRAIN);
         done <= (state_nxt == S_DONE);
      end
   end

endmodule

// File: doc/control_memw_seq.md
Name: control_memw_seq

Overview:
- Parametrised weight-memory bank sequencer that generates bank read selects and delayed write-back selects/enables for an NBANK-bank weight store.
- Owns its own stage sequencing with a start/advance/done handshake, configurable write-back latency, multi-pass streaming and abort.
- Sits between the layer controller and the MEMW bank mux.

Parameters:
NBANK, 4, number of weight banks (>=2)
SEL_W, 2, bank select width, clog2(NBANK)
WB_LAT, 1, cycles from read strobe to matching write strobe (>=1)
NPASS, 2, streaming passes over all banks per start
PASS_W, 8, pass counter width (2^PASS_W > NPASS)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin sequence; sampled only in IDLE
wb_mode  input  1  1 = read-modify-write, 0 = read-only; latched on accepted start
advance  input  1  step one bank; accepted only in PRIME/STREAM
abort  input  1  synchronous cancel; priority over all except rst
rden_MEMW  output  1  read strobe, one cycle per accepted advance
rdslc_MEMW  output  SEL_W  read bank select
wren_MEMW  output  1  write strobe
wrslc_MEMW  output  SEL_W  write bank select
busy  output  1  high in PRIME, STREAM, DRAIN
done  output  1  one-cycle completion pulse
pass_cnt  output  PASS_W  completed STREAM passes

Behaviour:
- Reset (rst=0, async): state=IDLE, bank=0, delay line cleared; all outputs 0.
- All outputs registered.
- States: IDLE, PRIME, STREAM, DRAIN, DONE.
- IDLE: start=1 -> PRIME; bank=0, pass_cnt=0, wb_mode latched. advance ignored.
- Accepted advance (PRIME or STREAM, advance=1):
  - next cycle rden_MEMW=1, rdslc_MEMW=bank.
  - bank increments, wrapping NBANK-1 -> 0.
  - rdslc_MEMW holds its last value when rden_MEMW=0.
- PRIME: reads each bank once, no writes. Advance accepted with bank==NBANK-1 -> STREAM.
- STREAM: each accepted advance with latched wb_mode=1 pushes {1,bank} into a WB_LAT-deep delay line.
  - wren_MEMW=1 and wrslc_MEMW=that bank exactly WB_LAT cycles after the matching rden_MEMW pulse.
  - wb_mode=0 pushes invalid entries, so wren_MEMW stays 0.
  - Advance accepted with bank==NBANK-1: pass_cnt+1. If the new pass_cnt==NPASS -> DRAIN.
- DRAIN: advance ignored. Delay line keeps shifting. When no valid entry remains -> DONE.
- DONE: done=1 for exactly one cycle; busy=0 in this cycle; next state IDLE.
- wrslc_MEMW holds its last value when wren_MEMW=0.
- start while busy or in DONE: ignored.
- abort=1 in any non-IDLE state:
  - next state IDLE; delay line flushed, so pending writes never issue.
  - bank=0; no done pulse; pass_cnt keeps its value until the next start.
- abort and start both high in IDLE: start wins.
- rden_MEMW and wren_MEMW may be high in the same cycle on different or equal banks; no arbitration here.
- Back-to-back advance every cycle is supported; throughput is one bank per cycle.

Test Plan:
- Reset: drive rst=0 mid-STREAM with pending writes, WB_LAT=2 -> all outputs 0 immediately; no wren after release; state IDLE.
- Nominal run, defaults, wb_mode=1, advance held high after start:
  - rdslc_MEMW sequence 0,1,2,3 (PRIME), then 0,1,2,3,0,1,2,3.
  - wren_MEMW high on the 8 STREAM reads only, wrslc_MEMW = rdslc_MEMW delayed 1 cycle.
  - pass_cnt ends at 2; done pulses 1 cycle after last wren; busy low with done.
- Read-only, wb_mode=0, NPASS=1 -> 8 rden pulses, zero wren pulses, done after DRAIN, pass_cnt=1.
- Latency, WB_LAT=3, advance toggled 1,0,1 in STREAM:
  - each wren exactly 3 cycles after its rden, with the same select.
  - gaps preserved; advance held high in DRAIN produces no rden.
- Abort one cycle after STREAM rden of bank 2, WB_LAT=2 -> no wren for bank 2, no done, busy low next cycle; a new start restarts at bank 0 in PRIME.
- Handshake edges:
  - start pulsed during STREAM -> ignored.
  - start+abort together in IDLE -> enters PRIME.
  - advance in IDLE -> no rden.
